countdown_timer: RTL and testbench

Microwave cook-time timer, directly downstream of the keypad encoder. Captures BCD digits strobed by the encoder (`D`, `loadn`) into an M:SS register, then counts down once per rising edge of the encoder's `pgt_1Hz` while cooking is enabled. Drives the magnetron enable, the display digits and a done flag to the display/control logic.

---
 rtl/countdown_timer_pkg.sv | 19 +
 rtl/countdown_timer_if.sv | 26 ++
 rtl/countdown_timer_bcd_down_digit.sv | 18 +
 rtl/countdown_timer.sv | 125 ++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared state encodings and BCD constants for the microwave cook-time timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] BcdMax     = 4'd9;
  localparam logic [3:0] TensReload = 4'd5;

  function automatic logic time_is_zero(logic [3:0] min_d, logic [3:0] tens_d,
                                        logic [3:0] ones_d);
    return (min_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Keypad-encoder inputs and display/control outputs of the cook-time timer.
interface countdown_timer_if;

  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       mag_on;
  logic       done;

  modport master (
    output D, loadn, pgt_1Hz, start, stop, door_closed,
    input  sec_ones, sec_tens, min_ones, mag_on, done
  );

  modport slave (
    input  D, loadn, pgt_1Hz, start, stop, door_closed,
    output sec_ones, sec_tens, min_ones, mag_on, done
  );

endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit; borrows and reloads when decremented from 0.
module countdown_timer_bcd_down_digit (
  input  logic [3:0] value,
  input  logic       dec_en,
  input  logic [3:0] reload,
  output logic [3:0] next,
  output logic       borrow
);

  always_comb begin
    borrow = dec_en && (value == 4'd0);
    next   = value;
    if (dec_en) begin
      next = (value == 4'd0) ? reload : value - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// M:SS cook timer: digit entry by shift-in, 1 Hz countdown, run/pause/done control.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned MIN_DIGITS = 1
) (
  input logic clk,
  input logic rst,
  countdown_timer_if.slave bus
);

  localparam int unsigned MinW = 4 * MIN_DIGITS;

  state_e            state_q, state_d;
  logic [3:0]        ones_q, ones_d, tens_q, tens_d;
  logic [MinW-1:0]   min_q, min_d;
  logic              loadn_q, loadn_prev_q, pgt_q, pgt_prev_q;
  logic              load_evt, tick, load_ok, time_zero, dec_zero;
  logic [3:0]        ones_dec, tens_dec, min_dec;
  logic              ones_borrow, tens_borrow, min_borrow;

  assign load_evt  = loadn_prev_q & ~loadn_q;
  assign tick      = ~pgt_prev_q & pgt_q;
  assign load_ok   = load_evt && (bus.D <= BcdMax);
  assign time_zero = time_is_zero(min_q, tens_q, ones_q);
  assign dec_zero  = time_is_zero(min_dec, tens_dec, ones_dec);

  countdown_timer_bcd_down_digit u_ones (
    .value  (ones_q),
    .dec_en (tick),
    .reload (BcdMax),
    .next   (ones_dec),
    .borrow (ones_borrow)
  );

  countdown_timer_bcd_down_digit u_tens (
    .value  (tens_q),
    .dec_en (ones_borrow),
    .reload (TensReload),
    .next   (tens_dec),
    .borrow (tens_borrow)
  );

  countdown_timer_bcd_down_digit u_min (
    .value  (min_q),
    .dec_en (tens_borrow),
    .reload (BcdMax),
    .next   (min_dec),
    .borrow (min_borrow)
  );

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    min_d   = min_q;
    unique case (state_q)
      StIdle: begin
        if (bus.stop) begin
          {min_d, tens_d, ones_d} = '0;
        end else if (bus.start && bus.door_closed && !time_zero) begin
          state_d = StRun;
        end else if (load_ok) begin
          {min_d, tens_d, ones_d} = {tens_q, ones_q, bus.D};
        end
      end
      StRun: begin
        if (bus.stop || !bus.door_closed) begin
          state_d = StPause;
        // min_borrow would mean wrapping below 0:00; never applied
        end else if (tick && !min_borrow) begin
          {min_d, tens_d, ones_d} = {min_dec, tens_dec, ones_dec};
          if (dec_zero) state_d = StDone;
        end
      end
      StPause: begin
        if (bus.stop) begin
          state_d = StIdle;
          {min_d, tens_d, ones_d} = '0;
        end else if (bus.start && bus.door_closed) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (bus.stop) begin
          state_d = StIdle;
          {min_d, tens_d, ones_d} = '0;
        end else if (load_evt) begin
          state_d = StIdle;
          if (load_ok) {min_d, tens_d, ones_d} = {tens_q, ones_q, bus.D};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ones_q       <= '0;
      tens_q       <= '0;
      min_q        <= '0;
      loadn_q      <= 1'b1;
      loadn_prev_q <= 1'b1;
      pgt_q        <= 1'b0;
      pgt_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      min_q        <= min_d;
      loadn_q      <= bus.loadn;
      loadn_prev_q <= loadn_q;
      pgt_q        <= bus.pgt_1Hz;
      pgt_prev_q   <= pgt_q;
    end
  end

  assign bus.sec_ones = ones_q;
  assign bus.sec_tens = tens_q;
  assign bus.min_ones = min_q;
  assign bus.mag_on   = (state_q == StRun);
  assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed test-plan sequences plus random stimulus against a digit-level timer model.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if bus ();

  countdown_timer #(.MIN_DIGITS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 idle, 1 cooking, 2 paused, 3 finished.
  int m_min, m_tens, m_ones, m_mode;
  bit ld_hist [2];
  bit pg_hist [2];

  task automatic model_reset();
    m_min = 0; m_tens = 0; m_ones = 0; m_mode = 0;
    ld_hist[0] = 1; ld_hist[1] = 1;
    pg_hist[0] = 0; pg_hist[1] = 0;
  endtask

  task automatic model_step();
    bit got_digit, got_second, has_time;
    int digit;
    if (rst) begin
      model_reset();
      return;
    end
    got_digit  = ld_hist[1] && !ld_hist[0];
    got_second = !pg_hist[1] && pg_hist[0];
    ld_hist[1] = ld_hist[0]; ld_hist[0] = bus.loadn;
    pg_hist[1] = pg_hist[0]; pg_hist[0] = bus.pgt_1Hz;
    digit    = int'(bus.D);
    has_time = (m_min + m_tens + m_ones) != 0;
    case (m_mode)
      0: begin
        if (bus.stop) begin
          m_min = 0; m_tens = 0; m_ones = 0;
        end else if (bus.start && bus.door_closed && has_time) begin
          m_mode = 1;
        end else if (got_digit && digit <= 9) begin
          m_min = m_tens; m_tens = m_ones; m_ones = digit;
        end
      end
      1: begin
        if (bus.stop || !bus.door_closed) begin
          m_mode = 2;
        end else if (got_second) begin
          if (m_ones > 0) m_ones--;
          else begin
            m_ones = 9;
            if (m_tens > 0) m_tens--;
            else begin
              m_tens = 5;
              m_min--;
            end
          end
          if (m_min == 0 && m_tens == 0 && m_ones == 0) m_mode = 3;
        end
      end
      2: begin
        if (bus.stop) begin
          m_mode = 0; m_min = 0; m_tens = 0; m_ones = 0;
        end else if (bus.start && bus.door_closed) begin
          m_mode = 1;
        end
      end
      default: begin
        if (bus.stop) begin
          m_mode = 0; m_min = 0; m_tens = 0; m_ones = 0;
        end else if (got_digit) begin
          m_mode = 0;
          if (digit <= 9) begin
            m_min = m_tens; m_tens = m_ones; m_ones = digit;
          end
        end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("model.sec_ones", int'(bus.sec_ones), m_ones);
        check("model.sec_tens", int'(bus.sec_tens), m_tens);
        check("model.min_ones", int'(bus.min_ones), m_min);
        check("model.mag_on", int'(bus.mag_on), (m_mode == 1) ? 1 : 0);
        check("model.done", int'(bus.done), (m_mode == 3) ? 1 : 0);
      end
    end
  end

  task automatic expect_disp(input string name, input int mn, input int tn, input int on,
                             input int mag, input int dn);
    check({name, ".min"}, int'(bus.min_ones), mn);
    check({name, ".tens"}, int'(bus.sec_tens), tn);
    check({name, ".ones"}, int'(bus.sec_ones), on);
    check({name, ".mag_on"}, int'(bus.mag_on), mag);
    check({name, ".done"}, int'(bus.done), dn);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int d);
    bus.D = 4'(d);
    bus.loadn = 1'b0;
    cyc(1);
    bus.loadn = 1'b1;
    cyc(2);
  endtask

  task automatic second_pulse();
    bus.pgt_1Hz = 1'b1;
    cyc(2);
    bus.pgt_1Hz = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    bus.D = 4'd0; bus.loadn = 1'b1; bus.pgt_1Hz = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_closed = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    expect_disp("reset", 0, 0, 0, 0, 0);

    strobe(1); strobe(3); strobe(0);
    expect_disp("entry", 1, 3, 0, 0, 0);
    strobe(12);
    expect_disp("entry_bad_digit", 1, 3, 0, 0, 0);
    pulse_stop();
    expect_disp("idle_clear", 0, 0, 0, 0, 0);

    strobe(3);
    pulse_start();
    expect_disp("run_start", 0, 0, 3, 1, 0);
    second_pulse();
    expect_disp("count_2", 0, 0, 2, 1, 0);
    second_pulse();
    expect_disp("count_1", 0, 0, 1, 1, 0);
    second_pulse();
    expect_disp("count_done", 0, 0, 0, 0, 1);

    strobe(1);
    expect_disp("done_load", 0, 0, 1, 0, 0);
    strobe(0); strobe(0);
    pulse_start();
    second_pulse();
    expect_disp("borrow_min", 0, 5, 9, 1, 0);
    pulse_stop(); pulse_stop();

    strobe(7); strobe(0);
    pulse_start();
    second_pulse();
    expect_disp("borrow_70", 0, 6, 9, 1, 0);
    pulse_stop(); pulse_stop();

    strobe(4); strobe(5);
    pulse_start();
    bus.door_closed = 1'b0;
    cyc(1);
    expect_disp("door_pause", 0, 4, 5, 0, 0);
    second_pulse();
    expect_disp("door_hold", 0, 4, 5, 0, 0);
    bus.door_closed = 1'b1;
    pulse_start();
    second_pulse();
    expect_disp("door_resume", 0, 4, 4, 1, 0);
    pulse_stop(); pulse_stop();

    strobe(2); strobe(0);
    pulse_start();
    pulse_stop();
    expect_disp("stop_pause", 0, 2, 0, 0, 0);
    pulse_stop();
    expect_disp("stop_idle", 0, 0, 0, 0, 0);
    pulse_start();
    cyc(1);
    expect_disp("start_zero", 0, 0, 0, 0, 0);

    strobe(2); strobe(1); strobe(5);
    pulse_start();
    expect_disp("run_215", 2, 1, 5, 1, 0);
    #2 rst = 1'b1;
    #1 expect_disp("async_reset", 0, 0, 0, 0, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    strobe(3); strobe(0);
    pulse_start();
    bus.pgt_1Hz = 1'b1;
    cyc(1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cyc(2);
    bus.pgt_1Hz = 1'b0;
    cyc(2);
    expect_disp("tick_vs_stop", 0, 3, 0, 0, 0);
    pulse_stop();

    for (int i = 0; i < 4000; i++) begin
      bus.D           = 4'($urandom_range(0, 11));
      bus.start       = ($urandom_range(0, 7) == 0);
      bus.stop        = ($urandom_range(0, 59) == 0);
      bus.door_closed = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) == 0) bus.loadn = ~bus.loadn;
      if ($urandom_range(0, 2) == 0) bus.pgt_1Hz = ~bus.pgt_1Hz;
      cyc(1);
    end

    bus.start = 1'b0; bus.stop = 1'b0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
